// File: rtl/slt_ctrl_seq_pkg.sv
// Shared definitions for the set-less-than sequencer and the ALU control decoder.
package slt_ctrl_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        EVAL  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [2:0] ALU_AND     = 3'b000;
    localparam logic [2:0] ALU_OR      = 3'b001;
    localparam logic [2:0] ALU_IDLE_OP = 3'b010;
    localparam logic [2:0] ALU_SUB_OP  = 3'b110;
    localparam logic [2:0] ALU_SLT     = 3'b111;

endpackage

// File: rtl/slt_flag_eval.sv
// Less-than flag from a subtract result: signed uses sign^overflow, unsigned uses borrow.
module slt_flag_eval (
    input  logic result_msb,
    input  logic overflow,
    input  logic carry,
    input  logic is_unsigned,
    output logic lt
);

    // carry = 1 means no borrow, so a borrow (carry = 0) means A < B unsigned
    assign lt = is_unsigned ? ~carry : (result_msb ^ overflow);

endmodule

// File: rtl/slt_ctrl_seq.sv
// Multicycle SLT/SLTU/SLTI/SLTIU sequencer driving the shared ALU as a subtractor.
module slt_ctrl_seq #(
    parameter int         WIDTH       = 32,
    parameter logic [2:0] ALU_SUB_OP  = slt_ctrl_seq_pkg::ALU_SUB_OP,
    parameter logic [2:0] ALU_IDLE_OP = slt_ctrl_seq_pkg::ALU_IDLE_OP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_unsigned,
    input  logic             use_imm,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [15:0]      imm16,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    output logic             slt_sel,
    output logic [WIDTH-1:0] slt_value,
    output logic             reg_write,
    output logic             busy,
    output logic             done
);
    import slt_ctrl_seq_pkg::*;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, b_sel;
    logic             uns_q, lt_q, lt_c;

    // Only the sign bit of the difference matters for the flag
    logic alu_result_unused;
    assign alu_result_unused = ^alu_result[WIDTH-2:0];

    // SLTIU still sign-extends its immediate before the unsigned compare
    assign b_sel = use_imm ? {{(WIDTH-16){imm16[15]}}, imm16} : rt_val;

    slt_flag_eval u_flag (
        .result_msb  (alu_result[WIDTH-1]),
        .overflow    (alu_overflow),
        .carry       (alu_carry),
        .is_unsigned (uns_q),
        .lt          (lt_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            uns_q <= 1'b0;
            lt_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                a_q   <= rs_val;
                b_q   <= b_sel;
                uns_q <= is_unsigned;
            end
            if (state == EVAL)
                lt_q <= lt_c;
        end
    end

    always_comb begin
        state_nx  = state;
        alu_a     = a_q;
        alu_b     = b_q;
        alu_op    = ALU_IDLE_OP;
        busy      = 1'b1;
        slt_sel   = 1'b0;
        reg_write = 1'b0;
        done      = 1'b0;
        slt_value = {{(WIDTH-1){1'b0}}, lt_q};
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nx = EXEC;
            end
            EXEC: begin
                alu_op   = ALU_SUB_OP;
                state_nx = EVAL;
            end
            EVAL: begin
                alu_op   = ALU_SUB_OP;
                state_nx = WRITE;
            end
            WRITE: begin
                slt_sel   = 1'b1;
                reg_write = 1'b1;
                done      = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_slt_ctrl_seq.sv
// Scoreboard bench for slt_ctrl_seq with a behavioural ALU model on its ALU ports.
module tb_slt_ctrl_seq;
    import slt_ctrl_seq_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic        is_unsigned = 1'b0, use_imm = 1'b0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic [15:0] imm16 = '0;
    logic [31:0] alu_a, alu_b, alu_result, slt_value;
    logic [2:0]  alu_op;
    logic        alu_overflow, alu_carry, slt_sel, reg_write, busy, done;

    slt_ctrl_seq dut (
        .clk(clk), .reset(reset), .start(start), .is_unsigned(is_unsigned),
        .use_imm(use_imm), .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_overflow(alu_overflow), .alu_carry(alu_carry), .slt_sel(slt_sel),
        .slt_value(slt_value), .reg_write(reg_write), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ALU model: subtract as A + ~B + 1, otherwise add
    logic [32:0] sum;
    always_comb begin
        sum = '0;
        alu_overflow = 1'b0;
        if (alu_op == ALU_SUB_OP) begin
            sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            alu_overflow = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
        end else begin
            sum = {1'b0, alu_a} + {1'b0, alu_b};
            alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
        end
    end
    assign alu_result = sum[31:0];
    assign alu_carry  = sum[32];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        int          scyc;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    int   tests = 0, fails = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && reg_write) begin
            if (q.size() == 0) begin
                chk("spurious reg_write", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("slt_value", slt_value, mon_e.val);
                chk("slt_sel", {31'd0, slt_sel}, 32'd1);
                chk("done", {31'd0, done}, 32'd1);
                chk("latency", cyc - mon_e.scyc, 32'd3);
                chk("done width", {31'd0, prev_done}, 32'd0);
            end
        end
        prev_done <= done;
    end

    // Drive one request in an IDLE cycle, then check the EXEC-cycle ALU drive
    task automatic issue(input logic u, input logic im, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [31:0] eb, input logic el, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1; is_unsigned = u; use_imm = im;
        rs_val = rs; rt_val = rt; imm16 = imm;
        if (push) begin
            e.val  = {31'd0, el};
            e.scyc = cyc;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        rs_val = $urandom; rt_val = $urandom; imm16 = 16'($urandom);
        is_unsigned = ~u; use_imm = ~im;
        chk("exec alu_a", alu_a, rs);
        chk("exec alu_b", alu_b, eb);
        chk("exec alu_op", {29'd0, alu_op}, {29'd0, ALU_SUB_OP});
        chk("exec busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(output int dc);
        int n = 0;
        dc = -1;
        while (!reg_write && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (!reg_write) chk("done timeout", 32'd0, 32'd1);
        else dc = cyc;
    endtask

    int d1, d2;

    initial begin
        #12;
        chk("reset alu_a", alu_a, 32'd0);
        chk("reset alu_b", alu_b, 32'd0);
        chk("reset alu_op", {29'd0, alu_op}, {29'd0, ALU_IDLE_OP});
        chk("reset busy/done/rw/sel", {28'd0, busy, done, reg_write, slt_sel}, 32'd0);
        chk("reset slt_value", slt_value, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        issue(0, 0, 32'hFFFFFFFF, 32'h00000001, 16'h0, 32'h00000001, 1'b1, 1); wait_done(d1);
        issue(1, 0, 32'hFFFFFFFF, 32'h00000001, 16'h0, 32'h00000001, 1'b0, 1); wait_done(d2);
        chk("back-to-back spacing", d2 - d1, 32'd4);
        issue(0, 0, 32'h12345678, 32'h12345678, 16'h0, 32'h12345678, 1'b0, 1); wait_done(d1);
        issue(1, 0, 32'h12345678, 32'h12345678, 16'h0, 32'h12345678, 1'b0, 1); wait_done(d1);
        issue(0, 0, 32'h80000000, 32'h00000001, 16'h0, 32'h00000001, 1'b1, 1); wait_done(d1);
        issue(0, 0, 32'h7FFFFFFF, 32'hFFFFFFFF, 16'h0, 32'hFFFFFFFF, 1'b0, 1); wait_done(d1);
        issue(1, 1, 32'h00000005, 32'h0, 16'hFFFF, 32'hFFFFFFFF, 1'b1, 1); wait_done(d1);
        issue(0, 1, 32'h00000005, 32'h0, 16'hFFFF, 32'hFFFFFFFF, 1'b0, 1); wait_done(d1);
        issue(0, 1, 32'hFFFFFFFE, 32'h0, 16'h0001, 32'h00000001, 1'b1, 1); wait_done(d1);
        issue(1, 0, 32'h00000001, 32'h80000000, 16'h0, 32'h80000000, 1'b1, 1); wait_done(d1);

        // Extra starts in EXEC, EVAL and WRITE must all be dropped
        issue(0, 0, 32'h00000003, 32'h00000007, 16'h0, 32'h00000007, 1'b1, 1);
        start = 1'b1; rs_val = 32'h7; rt_val = 32'h3;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        wait_done(d1);
        @(negedge clk);
        start = 1'b0;
        chk("idle after ignored starts", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);

        // Abort in EVAL: no write for the dropped op, next op runs clean
        issue(0, 0, 32'hFFFFFFFF, 32'h00000001, 16'h0, 32'h00000001, 1'b1, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort alu_op", {29'd0, alu_op}, {29'd0, ALU_IDLE_OP});
        chk("abort reg_write", {31'd0, reg_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        issue(1, 1, 32'h00000010, 32'h0, 16'h0020, 32'h00000020, 1'b1, 1); wait_done(d1);

        repeat (4) @(negedge clk);
        chk("scoreboard drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
